// File: rtl/hub75_bcm_matrix.sv
// HUB75/HUB75E scan driver with binary-coded modulation colour depth.
// Walks row pairs and shifts each bit-plane, displaying it for base_cycles << plane.
module hub75_bcm_matrix #(
  parameter int unsigned clk_mhz       = 50,
  parameter int unsigned screen_width  = 64,
  parameter int unsigned screen_height = 64,
  parameter int unsigned w_color       = 4,
  parameter int unsigned ck_div        = 2,
  parameter int unsigned base_cycles   = 16,
  parameter int unsigned blank_cycles  = 4,
  localparam int unsigned w_x = $clog2(screen_width),
  localparam int unsigned w_y = $clog2(screen_height / 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  input  logic [w_color-1:0] red1,
  input  logic [w_color-1:0] green1,
  input  logic [w_color-1:0] blue1,
  input  logic [w_color-1:0] red2,
  input  logic [w_color-1:0] green2,
  input  logic [w_color-1:0] blue2,
  output logic               ck,
  output logic               st,
  output logic               oe,
  output logic [w_y-1:0]     addr,
  output logic               r1,
  output logic               g1,
  output logic               b1,
  output logic               r2,
  output logic               g2,
  output logic               b2,
  output logic               frame_start
);

  localparam int unsigned disp_max = base_cycles << (w_color - 1);
  localparam int unsigned cnt_a    = (disp_max > ck_div) ? disp_max : ck_div;
  localparam int unsigned cnt_max  = (cnt_a > blank_cycles) ? cnt_a : blank_cycles;
  localparam int unsigned w_cnt    = $clog2(cnt_max + 1);
  localparam int unsigned w_p      = (w_color > 1) ? $clog2(w_color) : 1;

  if (clk_mhz == 0 || screen_width < 2 || ck_div < 2 || blank_cycles < 1 ||
      w_color < 1 || w_color > 8 || base_cycles < 1) begin : g_param_check
    $error("hub75_bcm_matrix: illegal parameter set");
  end

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_DISPLAY, S_BLANK} state_t;

  state_t           state, state_n;
  logic             started;
  logic             phase, phase_n;
  logic [w_cnt-1:0] cnt, cnt_n;
  logic [w_x-1:0]   col, col_n;
  logic [w_y-1:0]   row, row_n;
  logic [w_p-1:0]   plane, plane_n;
  logic [w_cnt-1:0] disp_last;
  logic             first_shift_n;
  logic             sample;

  // State register; started holds the start position for the first live cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_SHIFT;
      started <= 1'b0;
      phase   <= 1'b0;
      cnt     <= '0;
      col     <= '0;
      row     <= '0;
      plane   <= '0;
    end else begin
      state   <= state_n;
      started <= 1'b1;
      phase   <= phase_n;
      cnt     <= cnt_n;
      col     <= col_n;
      row     <= row_n;
      plane   <= plane_n;
    end
  end

  // Next-state sequencing: shift -> latch -> display -> blank.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = cnt + w_cnt'(1);
    col_n     = col;
    row_n     = row;
    plane_n   = plane;
    disp_last = (w_cnt'(base_cycles) << plane) - w_cnt'(1);
    if (!started) begin
      cnt_n = cnt;
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt == w_cnt'(ck_div - 1)) begin
            cnt_n   = '0;
            phase_n = ~phase;
            if (phase) begin
              if (col == w_x'(screen_width - 1)) begin
                col_n   = '0;
                state_n = S_LATCH;
              end else begin
                col_n = col + w_x'(1);
              end
            end
          end
        end
        S_LATCH: begin
          if (cnt == w_cnt'(ck_div - 1)) begin
            cnt_n   = '0;
            state_n = S_DISPLAY;
          end
        end
        S_DISPLAY: begin
          if (cnt == disp_last) begin
            cnt_n   = '0;
            state_n = S_BLANK;
          end
        end
        S_BLANK: begin
          if (cnt == w_cnt'(blank_cycles - 1)) begin
            cnt_n   = '0;
            state_n = S_SHIFT;
            if (plane == w_p'(w_color - 1)) begin
              plane_n = '0;
              row_n   = (row == w_y'(screen_height / 2 - 1)) ? '0 : row + w_y'(1);
            end else begin
              plane_n = plane + w_p'(1);
            end
          end
        end
        default: state_n = S_SHIFT;
      endcase
    end
  end

  assign first_shift_n = (state_n == S_SHIFT) && !phase_n && (cnt_n == '0) && (col_n == '0);
  assign sample        = started && (state == S_SHIFT) && !phase && (cnt == '0);

  // Registered panel outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      ck          <= 1'b0;
      st          <= 1'b0;
      oe          <= 1'b1;
      frame_start <= 1'b0;
      r1          <= 1'b0;
      g1          <= 1'b0;
      b1          <= 1'b0;
      r2          <= 1'b0;
      g2          <= 1'b0;
      b2          <= 1'b0;
    end else begin
      ck          <= (state_n == S_SHIFT) && phase_n;
      st          <= (state_n == S_LATCH);
      oe          <= (state_n != S_DISPLAY);
      frame_start <= first_shift_n && (plane_n == '0) && (row_n == '0);
      if (state_n == S_SHIFT) begin
        x <= col_n;
        y <= row_n;
      end
      if (first_shift_n && (plane_n == '0)) begin
        addr <= row_n;
      end
      if (sample) begin
        r1 <= red1[plane];
        g1 <= green1[plane];
        b1 <= blue1[plane];
        r2 <= red2[plane];
        g2 <= green2[plane];
        b2 <= blue2[plane];
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_matrix.sv
// Scoreboard bench: a cycle-position model predicts control outputs and the
// colour bits expected at every ck rising edge; a monitor compares.
module tb_hub75_bcm_matrix;

  localparam int W = 4, H = 4, WC = 2, CKD = 2, BASE = 4, BLANK = 2;
  localparam int H2 = H / 2;
  localparam int WX = $clog2(W);
  localparam int WY = $clog2(H2);
  localparam int SHIFT_LEN = 2 * CKD * W;
  localparam int ROW_LEN = WC * (SHIFT_LEN + CKD + BLANK) + BASE * ((1 << WC) - 1);
  localparam int FRAME = ROW_LEN * H2;

  typedef struct packed {
    logic [WX-1:0] x;
    logic [WY-1:0] y;
    logic          ck;
    logic          st;
    logic          oe;
    logic [WY-1:0] addr;
    logic          fs;
  } ctrl_t;

  typedef struct packed {
    ctrl_t c;
    logic  in_rst;
  } exp_t;

  typedef struct packed {
    logic [WC-1:0] r1, g1, b1, r2, g2, b2;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WX-1:0] x;
  logic [WY-1:0] y;
  logic [WC-1:0] red1, green1, blue1, red2, green2, blue2;
  logic ck, st, oe, r1, g1, b1, r2, g2, b2, frame_start;
  logic [WY-1:0] addr;

  pix_t mem [H2][W];
  exp_t ctrl_q[$];
  logic [5:0] pix_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hub75_bcm_matrix #(
    .clk_mhz(50), .screen_width(W), .screen_height(H), .w_color(WC),
    .ck_div(CKD), .base_cycles(BASE), .blank_cycles(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .red1(red1), .green1(green1), .blue1(blue1),
    .red2(red2), .green2(green2), .blue2(blue2),
    .ck(ck), .st(st), .oe(oe), .addr(addr),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .frame_start(frame_start)
  );

  // Pixel source: combinational lookup, valid well before the sampling edge.
  always_comb begin
    red1   = mem[y][x].r1;
    green1 = mem[y][x].g1;
    blue1  = mem[y][x].b1;
    red2   = mem[y][x].r2;
    green2 = mem[y][x].g2;
    blue2  = mem[y][x].b2;
  end

  function automatic int plen(input int p);
    return SHIFT_LEN + CKD + (BASE << p) + BLANK;
  endfunction

  // Expected outputs for the k-th cycle after reset release (k >= 1).
  function automatic void model(input int k, output ctrl_t c, output logic evt,
                                output int row, output int col, output int p);
    int f, s, ph;
    f   = (k - 1) % FRAME;
    row = f / ROW_LEN;
    s   = f % ROW_LEN;
    p   = 0;
    col = 0;
    evt = 1'b0;
    while (s >= plen(p)) begin
      s = s - plen(p);
      p = p + 1;
    end
    c      = '0;
    c.oe   = 1'b1;
    c.y    = WY'(row);
    c.addr = WY'(row);
    c.fs   = (f == 0);
    if (s < SHIFT_LEN) begin
      col  = s / (2 * CKD);
      ph   = s % (2 * CKD);
      c.x  = WX'(col);
      c.ck = (ph >= CKD);
      evt  = (ph == CKD);
    end else begin
      c.x = WX'(W - 1);
      if (s < SHIFT_LEN + CKD) c.st = 1'b1;
      else if (s < SHIFT_LEN + CKD + (BASE << p)) c.oe = 1'b0;
    end
  endfunction

  // Stimulus side: predicts each cycle's outputs and queues them.
  initial begin
    int k, row, col, p;
    logic evt;
    ctrl_t c;
    exp_t e;
    k = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        e.c = '0;
        e.c.oe = 1'b1;
        e.in_rst = 1'b1;
      end else begin
        k = k + 1;
        model(k, c, evt, row, col, p);
        e.c = c;
        e.in_rst = 1'b0;
        if (evt) begin
          pix_q.push_back({mem[row][col].r1[p], mem[row][col].g1[p], mem[row][col].b1[p],
                           mem[row][col].r2[p], mem[row][col].g2[p], mem[row][col].b2[p]});
        end
      end
      ctrl_q.push_back(e);
    end
  end

  // Monitor: compares control every cycle and colour bits at each ck rise.
  initial begin
    logic prev_ck;
    exp_t e;
    ctrl_t got;
    logic [5:0] pe, pg;
    prev_ck = 1'b0;
    forever begin
      @(negedge clk);
      if (ctrl_q.size() > 0) begin
        e = ctrl_q.pop_front();
        got.x = x; got.y = y; got.ck = ck; got.st = st; got.oe = oe;
        got.addr = addr; got.fs = frame_start;
        checks++;
        if (got !== e.c) begin
          errors++;
          $display("FAIL ctrl t=%0t got x=%0d y=%0d ck=%b st=%b oe=%b addr=%0d fs=%b exp x=%0d y=%0d ck=%b st=%b oe=%b addr=%0d fs=%b",
                   $time, got.x, got.y, got.ck, got.st, got.oe, got.addr, got.fs,
                   e.c.x, e.c.y, e.c.ck, e.c.st, e.c.oe, e.c.addr, e.c.fs);
        end
        if (e.in_rst) begin
          checks++;
          if ({r1, g1, b1, r2, g2, b2} !== 6'b0) begin
            errors++;
            $display("FAIL rst_colour t=%0t got=%b exp=000000", $time, {r1, g1, b1, r2, g2, b2});
          end
        end
      end
      if (ck === 1'b1 && prev_ck === 1'b0) begin
        checks++;
        pg = {r1, g1, b1, r2, g2, b2};
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL pix_unexpected t=%0t got=%b exp=no_edge", $time, pg);
        end else begin
          pe = pix_q.pop_front();
          if (pg !== pe) begin
            errors++;
            $display("FAIL pix t=%0t got=%b exp=%b", $time, pg, pe);
          end
        end
      end
      prev_ck = ck;
    end
  end

  task automatic set_mem(input int mode);
    for (int yy = 0; yy < H2; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        mem[yy][xx] = '0;
        case (mode)
          0: mem[yy][xx].r1 = WC'(1);
          1: mem[yy][xx].r2 = WC'(3);
          2: mem[yy][xx].r1 = WC'(xx);
          default: mem[yy][xx] = pix_t'($urandom);
        endcase
      end
    end
  endtask

  task automatic do_reset(input int n, input int mode);
    rst_n = 1'b0;
    set_mem(mode);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    set_mem(0);
    @(negedge clk);
    do_reset(3, 0);
    run(2 * FRAME + 8);
    do_reset(2, 1);
    run(FRAME);
    do_reset(2, 2);
    run(FRAME);
    do_reset(1, 3);
    run(20);
    do_reset(1, 3);
    run(3 * FRAME);
    do_reset(2, 3);
    run(FRAME + 30);
    @(negedge clk);
    #1;
    checks++;
    if (pix_q.size() != 0) begin
      errors++;
      $display("FAIL pix_missing got=%0d_pending exp=0", pix_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
